// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 1 start, 8 data (MSB first), odd parity, 1 stop.
// Mid-bit sampling driven by a baud counter; byte handed off on a valid/ready port.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rd_data,
    output logic       rd_vld,
    input  logic       rd_rdy,
    output logic       rd_perr,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic            r_rx_d;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shreg;
    logic            r_perr_pend;
    logic [7:0]      r_rd_data;
    logic            r_rd_vld;
    logic            r_rd_perr;
    logic            r_frame_err;
    logic            r_overrun;

    logic w_fall;
    logic w_sample;
    logic w_deliver;
    logic w_stop_bad;
    logic w_accept;

    assign w_fall     = !r_rx_s && r_rx_d;
    // START samples half a bit in; every later bit is one full bit after the previous sample.
    assign w_sample   = (r_state == S_START) ? (r_baud == HALF_M1) : (r_baud == FULL_M1);
    assign w_deliver  = (r_state == S_STOP) && w_sample && r_rx_s;
    assign w_stop_bad = (r_state == S_STOP) && w_sample && !r_rx_s;
    assign w_accept   = !r_rd_vld || rd_rdy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_nxt = S_START;
            S_START:  if (w_sample) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_sample && (r_bitcnt == 3'd7)) w_state_nxt = S_PARITY;
            S_PARITY: if (w_sample) w_state_nxt = S_STOP;
            S_STOP:   if (w_sample) w_state_nxt = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (r_rx_s) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_d      <= 1'b1;
            r_baud      <= '0;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_perr_pend <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;

            if ((r_state == S_IDLE) || (r_state == S_BREAK) || w_sample)
                r_baud <= '0;
            else
                r_baud <= r_baud + CW'(1);

            if (r_state == S_IDLE)
                r_bitcnt <= '0;
            else if ((r_state == S_DATA) && w_sample) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shreg  <= {r_shreg[6:0], r_rx_s};
            end

            // Odd parity: an even count of ones over data+parity is an error.
            if ((r_state == S_PARITY) && w_sample)
                r_perr_pend <= ~^{r_shreg, r_rx_s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data   <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_perr   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_deliver && !w_accept;
            if (w_deliver && w_accept) begin
                r_rd_data <= r_shreg;
                r_rd_perr <= r_perr_pend;
                r_rd_vld  <= 1'b1;
            end else if (r_rd_vld && rd_rdy) begin
                r_rd_vld  <= 1'b0;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_vld    = r_rd_vld;
    assign rd_perr   = r_rd_perr;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: timing, parity, framing, glitch,
// overrun and mid-frame reset scenarios with hand-computed expectations.
module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rd_data;
    logic       rd_vld;
    logic       rd_rdy = 1'b0;
    logic       rd_perr;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Monitor state, written only by the negedge monitor.
    int         n_rise = 0;
    int         rise_cyc = -1;
    logic [7:0] rise_data = '0;
    logic       rise_perr = 1'b0;
    int         n_ferr = 0;
    int         ferr_cyc = -1;
    int         n_ovr = 0;
    int         ovr_cyc = -1;
    logic       prev_vld = 1'b0;

    uart_rx_deframer #(.CLKS_PER_BIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .rd_rdy    (rd_rdy),
        .rd_perr   (rd_perr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_vld && !prev_vld) begin
            n_rise    = n_rise + 1;
            rise_cyc  = cyc;
            rise_data = rd_data;
            rise_perr = rd_perr;
        end
        if (frame_err) begin
            n_ferr   = n_ferr + 1;
            ferr_cyc = cyc;
        end
        if (overrun) begin
            n_ovr   = n_ovr + 1;
            ovr_cyc = cyc;
        end
        prev_vld = rd_vld;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame at the pin; c0 is the cycle the start bit appears.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp, output int c0);
        rx = 1'b0;
        c0 = cyc;
        cycles(16);
        for (int i = 7; i >= 0; i--) begin
            rx = d[i];
            cycles(16);
        end
        rx = p;
        cycles(16);
        rx = stp;
        cycles(16);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        cycles(3);
        ntests++;
        if ({rd_vld, rd_perr, frame_err, overrun, busy} !== 5'b0 || rd_data !== 8'h00) begin
            nfail++;
            $display("FAIL reset_outputs: got vld=%b perr=%b ferr=%b ovr=%b busy=%b data=%h, want all zero",
                     rd_vld, rd_perr, frame_err, overrun, busy, rd_data);
        end
        rst = 1'b0;
        cycles(5);
        ntests++;
        if (busy !== 1'b0 || rd_vld !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release: got busy=%b vld=%b, want 0 0", busy, rd_vld);
        end
    endtask

    task automatic test_timing();
        int c0, r0, f0, o0;
        rd_rdy = 1'b1;
        r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b1, 1'b1, c0);
        cycles(10);
        ntests++;
        if (n_rise - r0 !== 1) begin
            nfail++;
            $display("FAIL timing_count: got %0d deliveries, want 1", n_rise - r0);
        end
        // Two synchronizer cycles plus 169 from the rx_s edge.
        ntests++;
        if (rise_cyc !== c0 + 171) begin
            nfail++;
            $display("FAIL timing_latency: got rise at pin+%0d, want pin+171", rise_cyc - c0);
        end
        ntests++;
        if (rise_data !== 8'hA5 || rise_perr !== 1'b0) begin
            nfail++;
            $display("FAIL timing_data: got %h perr=%b, want a5 perr=0", rise_data, rise_perr);
        end
        ntests++;
        if (n_ferr != f0 || n_ovr != o0 || rd_vld !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL timing_flags: got ferr+%0d ovr+%0d vld=%b busy=%b, want 0 0 0 0",
                     n_ferr - f0, n_ovr - o0, rd_vld, busy);
        end
    endtask

    task automatic test_parity_err();
        int c0;
        rd_rdy = 1'b0;
        send_frame(8'h00, 1'b0, 1'b1, c0);
        cycles(10);
        ntests++;
        if (rd_vld !== 1'b1 || rd_data !== 8'h00 || rd_perr !== 1'b1) begin
            nfail++;
            $display("FAIL parity_err: got vld=%b data=%h perr=%b, want 1 00 1", rd_vld, rd_data, rd_perr);
        end
        rd_rdy = 1'b1;
        cycles(1);
        rd_rdy = 1'b0;
        ntests++;
        if (rd_vld !== 1'b0) begin
            nfail++;
            $display("FAIL parity_consume: got vld=%b, want 0", rd_vld);
        end
    endtask

    task automatic test_framing();
        int c0, r0, f0;
        rd_rdy = 1'b1;
        r0 = n_rise; f0 = n_ferr;
        send_frame(8'h5A, 1'b1, 1'b0, c0);
        cycles(40);
        ntests++;
        if (n_ferr - f0 !== 1 || ferr_cyc !== c0 + 171) begin
            nfail++;
            $display("FAIL framing_pulse: got %0d high cycles at pin+%0d, want 1 at pin+171",
                     n_ferr - f0, ferr_cyc - c0);
        end
        ntests++;
        if (busy !== 1'b1 || n_rise != r0) begin
            nfail++;
            $display("FAIL framing_break: got busy=%b deliveries+%0d, want 1 0", busy, n_rise - r0);
        end
        rx = 1'b1;
        cycles(4);
        ntests++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL framing_release: got busy=%b, want 0", busy);
        end
        send_frame(8'h5A, 1'b1, 1'b1, c0);
        cycles(10);
        ntests++;
        if (n_rise - r0 !== 1 || rise_data !== 8'h5A || rise_perr !== 1'b0) begin
            nfail++;
            $display("FAIL framing_recover: got deliveries+%0d data=%h perr=%b, want 1 5a 0",
                     n_rise - r0, rise_data, rise_perr);
        end
    endtask

    task automatic test_glitch();
        int r0, f0, o0;
        r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
        rx = 1'b0;
        cycles(3);
        rx = 1'b1;
        cycles(2);
        ntests++;
        if (busy !== 1'b1) begin
            nfail++;
            $display("FAIL glitch_start: got busy=%b, want 1", busy);
        end
        cycles(15);
        ntests++;
        if (busy !== 1'b0 || n_rise != r0 || n_ferr != f0 || n_ovr != o0 || rd_vld !== 1'b0) begin
            nfail++;
            $display("FAIL glitch_abort: got busy=%b deliveries+%0d ferr+%0d ovr+%0d vld=%b, want all 0",
                     busy, n_rise - r0, n_ferr - f0, n_ovr - o0, rd_vld);
        end
    endtask

    task automatic test_back_to_back();
        int c0a, c0b, r0, o0;
        rd_rdy = 1'b0;
        r0 = n_rise; o0 = n_ovr;
        send_frame(8'h12, 1'b1, 1'b1, c0a);
        send_frame(8'h34, 1'b0, 1'b1, c0b);
        cycles(10);
        ntests++;
        if (rd_vld !== 1'b1 || rd_data !== 8'h12 || rd_perr !== 1'b0 || n_rise - r0 !== 1) begin
            nfail++;
            $display("FAIL b2b_hold: got vld=%b data=%h perr=%b deliveries+%0d, want 1 12 0 1",
                     rd_vld, rd_data, rd_perr, n_rise - r0);
        end
        ntests++;
        if (n_ovr - o0 !== 1 || ovr_cyc !== c0b + 171) begin
            nfail++;
            $display("FAIL b2b_overrun: got %0d high cycles at pin+%0d, want 1 at pin+171",
                     n_ovr - o0, ovr_cyc - c0b);
        end
        rd_rdy = 1'b1;
        cycles(1);
        rd_rdy = 1'b0;
        ntests++;
        if (rd_vld !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_consume: got vld=%b, want 0", rd_vld);
        end
        cycles(20);
        ntests++;
        if (n_rise - r0 !== 1 || rd_vld !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_dropped: got deliveries+%0d vld=%b, want 1 0", n_rise - r0, rd_vld);
        end
    endtask

    task automatic test_reset_mid();
        int c0, r0;
        rd_rdy = 1'b1;
        r0 = n_rise;
        rx = 1'b0;
        cycles(16);
        rx = 1'b1;
        cycles(16 * 3 + 8);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        ntests++;
        if ({rd_vld, rd_perr, frame_err, overrun, busy} !== 5'b0 || rd_data !== 8'h00) begin
            nfail++;
            $display("FAIL midreset_outputs: got vld=%b perr=%b ferr=%b ovr=%b busy=%b data=%h, want all zero",
                     rd_vld, rd_perr, frame_err, overrun, busy, rd_data);
        end
        cycles(16 * 7);
        ntests++;
        if (n_rise != r0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL midreset_nobyte: got deliveries+%0d busy=%b, want 0 0", n_rise - r0, busy);
        end
        send_frame(8'h3C, 1'b1, 1'b1, c0);
        cycles(10);
        ntests++;
        if (n_rise - r0 !== 1 || rise_data !== 8'h3C || rise_perr !== 1'b0) begin
            nfail++;
            $display("FAIL midreset_recover: got deliveries+%0d data=%h perr=%b, want 1 3c 0",
                     n_rise - r0, rise_data, rise_perr);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_timing();
        test_parity_err();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side deframer for the team's UART link.
- Consumes the serial line driven by our UART transmitter. Each frame is: 1 start bit (0), 8 data bits MSB first, 1 odd-parity bit, 1 stop bit (1).
- Recovers each byte by mid-bit sampling and presents it on a valid/ready byte interface with parity, framing and overrun status.
- Sits between the rx pad and the command reassembly logic.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit. Must be even and >= 4.

Ports:
- clk  input  1  single system clock.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line; idles high.
- rd_data  output  8  received byte.
- rd_vld  output  1  rd_data, rd_perr are valid.
- rd_rdy  input  1  consumer accepts the byte; a transfer occurs when rd_vld && rd_rdy.
- rd_perr  output  1  parity error flag qualified with rd_vld.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a byte is dropped because the holding register is full.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset and clocking:
  - Single clock; reset is synchronous and active-high.
  - On rst: FSM=IDLE; synchronizer flops=1; rd_vld=0, rd_data=0, rd_perr=0, frame_err=0, overrun=0, busy=0. Any partial frame is discarded.
- Synchronizer:
  - 2-flop synchronizer rx -> rx_s, plus a delayed copy rx_d for edge detection. Pin-to-rx_s latency is 2 cycles.
- Sample timing:
  - Let T be the cycle with rx_s=0 and rx_d=1 (falling edge) while in IDLE.
  - Bit k (k=0 start, 1..8 data, 9 parity, 10 stop) is sampled at cycle T + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
  - Timing comes from a baud counter, width ceil(log2(CLKS_PER_BIT)), cleared at T, plus a 3-bit data-bit counter.
- FSM states and transitions:
  - IDLE: on the falling edge -> START.
  - START: at the sample point, rx_s=1 is a glitch -> IDLE with no flags; rx_s=0 -> DATA.
  - DATA: at each sample, shreg <= {shreg[6:0], rx_s}. After the 8th bit -> PARITY.
  - PARITY: sample the parity bit p; perr = ~^{shreg,p}, i.e. an error when the count of ones over data+parity is even. -> STOP.
  - STOP, rx_s=1: deliver the byte, -> IDLE in the same cycle. Returning at mid-stop gives half a bit of slack, so back-to-back frames are not missed.
  - STOP, rx_s=0: frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait for rx_s=1, then -> IDLE. No edge detection happens in BREAK.
- Delivery (at the stop sample cycle S):
  - If rd_vld=0, or rd_vld&&rd_rdy in cycle S: load rd_data=shreg and rd_perr=perr; rd_vld=1 from S+1.
  - Otherwise: the held byte is kept unchanged, the new byte is dropped, and overrun=1 for cycle S+1.
- Output handshake:
  - rd_data and rd_perr are stable while rd_vld && !rd_rdy.
  - rd_vld falls the cycle after a transfer unless a new byte loads in that same cycle.
  - rd_rdy while rd_vld=0 has no effect.
- Reset mid-frame: returns to IDLE immediately; a frame that starts later is received normally.
- End-to-end latency: from the start-bit edge at rx_s to rd_vld high is CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles (169 for the default).

Test Plan:
- Reception timing: CLKS_PER_BIT=16, hold rd_rdy=1, send frame 0,1,0,1,0,0,1,0,1,1,1 -> rd_vld pulses 169 cycles after the rx_s falling edge with rd_data=0xA5, rd_perr=0, no error pulses.
- Parity error: send 0x00 with parity bit 0 -> rd_data=0x00, rd_vld=1, rd_perr=1.
- Framing error: send 0x5A with correct parity and stop bit 0, holding rx low 40 more cycles -> frame_err one-cycle pulse, rd_vld stays 0, busy high until rx returns high. A following 0x5A frame is then received correctly.
- Glitch rejection: drive rx low for 3 cycles -> START aborts at the sample point, busy returns 0, no rd_vld, no flags.
- Back-to-back with stalled consumer: frames 0x12 then 0x34, rd_rdy=0 -> rd_vld=1, rd_data=0x12 held; overrun pulses one cycle after the second stop sample. Then rd_rdy=1 for one cycle -> rd_vld=0 next cycle, and 0x34 never appears.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0xFF -> outputs return to reset values, no byte delivered. A subsequent frame 0x3C is received with rd_perr=0.
